// File: rtl/axis_stream_fifo.sv
// AXI4-Stream first-word-fall-through FIFO with beat and packet occupancy counters.
// Define AXIS_STREAM_FIFO_PKT_MODE_EN to hold beats until a whole packet is stored.
module axis_stream_fifo #(
  parameter int unsigned TDATA_WIDTH = 128,
  parameter int unsigned TUSER_WIDTH = 8,
  parameter int unsigned DEPTH       = 16
) (
  input  logic                         clk,
  input  logic                         rst,

  input  logic [TDATA_WIDTH-1:0]       s_tdata,
  input  logic                         s_tlast,
  input  logic [TDATA_WIDTH/8-1:0]     s_tstrb,
  input  logic [TUSER_WIDTH-1:0]       s_tuser,
  input  logic                         s_tvalid,
  output logic                         s_tready,

  output logic [TDATA_WIDTH-1:0]       m_tdata,
  output logic                         m_tlast,
  output logic [TDATA_WIDTH/8-1:0]     m_tstrb,
  output logic [TUSER_WIDTH-1:0]       m_tuser,
  output logic                         m_tvalid,
  input  logic                         m_tready,

  output logic [$clog2(DEPTH):0]       count,
  output logic [$clog2(DEPTH):0]       pkt_cnt,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned StrbW = TDATA_WIDTH / 8;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CW    = AW + 1;
  localparam int unsigned BeatW = TDATA_WIDTH + StrbW + TUSER_WIDTH + 1;

  logic [BeatW-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [BeatW-1:0] head;
  logic             push, pop;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  // Full blocks acceptance even when a pop happens in the same cycle.
  assign s_tready = !full && !rst;
  assign push     = s_tvalid && s_tready;
  assign pop      = m_tvalid && m_tready;
  assign head     = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {s_tdata, s_tstrb, s_tuser, s_tlast};
    end
  end

`ifdef AXIS_STREAM_FIFO_PKT_MODE_EN
  logic [CW-1:0] pkt_cnt_q, pkt_cnt_d;
  logic          pkt_in, pkt_out;

  assign pkt_in  = push && s_tlast;
  assign pkt_out = pop && head[0];

  always_comb begin
    unique case ({pkt_in, pkt_out})
      2'b10:   pkt_cnt_d = pkt_cnt_q + CW'(1);
      2'b01:   pkt_cnt_d = pkt_cnt_q - CW'(1);
      default: pkt_cnt_d = pkt_cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt_q <= '0;
    end else begin
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  assign pkt_cnt  = pkt_cnt_q;
  // A full FIFO releases beats early so packets longer than DEPTH cannot deadlock.
  assign m_tvalid = !empty && ((pkt_cnt_q != '0) || full);
`else
  assign pkt_cnt  = '0;
  assign m_tvalid = !empty;
`endif

  always_comb begin
    {m_tdata, m_tstrb, m_tuser, m_tlast} = m_tvalid ? head : '0;
  end

endmodule

// File: tb/tb_axis_stream_fifo.sv
// Directed self-checking bench for axis_stream_fifo (default parameters).
// Packet-mode steps are compiled in when AXIS_STREAM_FIFO_PKT_MODE_EN is defined.
module tb_axis_stream_fifo;

  localparam int DW = 128;
  localparam int UW = 8;
  localparam int SW = DW / 8;
  localparam int D  = 16;
  localparam int CW = $clog2(D) + 1;
`ifdef AXIS_STREAM_FIFO_PKT_MODE_EN
  localparam logic PKT = 1'b1;
`else
  localparam logic PKT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_tdata;
  logic          s_tlast;
  logic [SW-1:0] s_tstrb;
  logic [UW-1:0] s_tuser;
  logic          s_tvalid;
  logic          s_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tlast;
  logic [SW-1:0] m_tstrb;
  logic [UW-1:0] m_tuser;
  logic          m_tvalid;
  logic          m_tready;
  logic [CW-1:0] count;
  logic [CW-1:0] pkt_cnt;
  logic          full;
  logic          empty;

  int checks = 0;
  int errors = 0;

  axis_stream_fifo #(
    .TDATA_WIDTH(DW),
    .TUSER_WIDTH(UW),
    .DEPTH      (D)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .s_tdata (s_tdata),
    .s_tlast (s_tlast),
    .s_tstrb (s_tstrb),
    .s_tuser (s_tuser),
    .s_tvalid(s_tvalid),
    .s_tready(s_tready),
    .m_tdata (m_tdata),
    .m_tlast (m_tlast),
    .m_tstrb (m_tstrb),
    .m_tuser (m_tuser),
    .m_tvalid(m_tvalid),
    .m_tready(m_tready),
    .count   (count),
    .pkt_cnt (pkt_cnt),
    .full    (full),
    .empty   (empty)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [DW-1:0] dat(input int v);
    return {32'(v), 64'h0, 32'(v)};
  endfunction

  function automatic logic [SW+UW:0] side(input int v, input logic last);
    return {~16'(v), 8'(v) ^ 8'h5A, last};
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_beat(input int v, input logic last);
    s_tdata = dat(v);
    s_tstrb = ~16'(v);
    s_tuser = 8'(v) ^ 8'h5A;
    s_tlast = last;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Streams n beats (base..base+n-1, tlast on the final one) and checks order and sideband.
  task automatic stream(input int n, input int base, input bit rnd, input string tag);
    int   sent = 0;
    int   got  = 0;
    int   cyc  = 0;
    bit   seen_full = 1'b0;
    logic acc;
    while (got < n && cyc < 3000) begin
      if (!s_tvalid && sent < n && (!rnd || $urandom_range(1) == 1)) begin
        drive_beat(base + sent, sent == n - 1);
        s_tvalid = 1'b1;
      end
      m_tready = rnd ? 1'($urandom_range(1)) : 1'b1;
      #1;
      if (full && !seen_full) begin
        seen_full = 1'b1;
        check({tag, "_full_vld"}, DW'(m_tvalid), DW'(1));
      end
      if (m_tvalid && m_tready) begin
        check({tag, "_data"}, m_tdata, dat(base + got));
        check({tag, "_side"}, DW'({m_tstrb, m_tuser, m_tlast}),
              DW'(side(base + got, got == n - 1)));
        got++;
      end
      acc = s_tvalid && s_tready;
      step();
      if (acc) begin
        sent++;
        s_tvalid = 1'b0;
      end
      cyc++;
    end
    check({tag, "_delivered"}, DW'(got), DW'(n));
  endtask

  initial begin
    rst      = 1'b1;
    s_tvalid = 1'b0;
    m_tready = 1'b0;
    drive_beat(0, 1'b0);
    step();
    step();

    // Reset state
    check("rst_count", DW'(count), DW'(0));
    check("rst_pkt_cnt", DW'(pkt_cnt), DW'(0));
    check("rst_empty", DW'(empty), DW'(1));
    check("rst_full", DW'(full), DW'(0));
    check("rst_m_tvalid", DW'(m_tvalid), DW'(0));
    check("rst_s_tready", DW'(s_tready), DW'(0));
    check("rst_m_tdata", m_tdata, DW'(0));
    rst = 1'b0;
    #1;
    check("rel_s_tready", DW'(s_tready), DW'(1));

    // Single beat, one-cycle fall-through latency
    drive_beat(32'hA5, 1'b1);
    s_tvalid = 1'b1;
    m_tready = 1'b1;
    step();
    s_tvalid = 1'b0;
    check("single_vld", DW'(m_tvalid), DW'(1));
    check("single_data", m_tdata, dat(32'hA5));
    check("single_pkt_cnt", DW'(pkt_cnt), DW'(PKT));
    step();
    check("single_empty", DW'(empty), DW'(1));
    check("single_vld_off", DW'(m_tvalid), DW'(0));
    check("single_data_zero", m_tdata, DW'(0));

    // Fill to DEPTH, refuse the extra beat, then free one slot
    m_tready = 1'b0;
    for (int i = 0; i < D; i++) begin
      drive_beat(i, i == D - 1);
      s_tvalid = 1'b1;
      step();
    end
    check("fill_count", DW'(count), DW'(D));
    check("fill_full", DW'(full), DW'(1));
    check("fill_s_tready", DW'(s_tready), DW'(0));
    check("fill_head", m_tdata, dat(0));
    check("fill_pkt_cnt", DW'(pkt_cnt), DW'(PKT));
    drive_beat(99, 1'b1);
    step();
    check("fill_17th_count", DW'(count), DW'(D));
    check("fill_17th_pkt_cnt", DW'(pkt_cnt), DW'(PKT));
    m_tready = 1'b1;
    step();
    s_tvalid = 1'b0;
    check("pop_count", DW'(count), DW'(D - 1));
    check("pop_s_tready", DW'(s_tready), DW'(1));
    for (int i = 1; i < D; i++) begin
      check("drain_data", m_tdata, dat(i));
      step();
    end
    check("drain_empty", DW'(empty), DW'(1));
    check("drain_pkt_cnt", DW'(pkt_cnt), DW'(0));

    // Pointer wrap under random stalls on both sides
    stream(40, 0, 1'b1, "wrap");
    check("wrap_count", DW'(count), DW'(0));

`ifdef AXIS_STREAM_FIFO_PKT_MODE_EN
    // Store-and-forward: nothing leaves until tlast is stored
    m_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_beat(100 + i, i == 3);
      s_tvalid = 1'b1;
      step();
      if (i < 3) check("pkt_hold_vld", DW'(m_tvalid), DW'(0));
    end
    s_tvalid = 1'b0;
    check("pkt_cnt_one", DW'(pkt_cnt), DW'(1));
    for (int i = 0; i < 4; i++) begin
      check("pkt_out_vld", DW'(m_tvalid), DW'(1));
      check("pkt_out_data", m_tdata, dat(100 + i));
      step();
    end
    check("pkt_cnt_zero", DW'(pkt_cnt), DW'(0));
    check("pkt_empty", DW'(empty), DW'(1));

    // Overlong packet cuts through once full
    stream(20, 500, 1'b0, "long");
    check("long_count", DW'(count), DW'(0));
`endif

    // Reset in the middle of a packet discards everything
    m_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_beat(200 + i, 1'b0);
      s_tvalid = 1'b1;
      step();
    end
    s_tvalid = 1'b0;
    check("mid_count", DW'(count), DW'(5));
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_count", DW'(count), DW'(0));
    check("mid_rst_vld", DW'(m_tvalid), DW'(0));
    check("mid_rst_pkt_cnt", DW'(pkt_cnt), DW'(0));
    check("mid_rst_empty", DW'(empty), DW'(1));
    stream(3, 300, 1'b0, "post_rst");
    check("post_rst_count", DW'(count), DW'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_stream_fifo.md
AXIS_STREAM_FIFO -- requirements
Module: axis_stream_fifo

Interface
REQ-001 The block SHALL have parameter TDATA_WIDTH, default 128, meaning the tdata width in bits, which SHALL be a multiple of 8.
REQ-002 The block SHALL have parameter TUSER_WIDTH, default 8, meaning the sideband tuser width in bits, which SHALL be at least 1.
REQ-003 The block SHALL have parameter DEPTH, default 16, meaning the number of beat entries, which SHALL be a power of 2 and at least 2.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is clocked on the rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have slave ports s_tdata (TDATA_WIDTH), s_tlast (1), s_tstrb (TDATA_WIDTH/8), s_tuser (TUSER_WIDTH) and s_tvalid (1) as inputs, and s_tready (1) as an output.
REQ-007 The block SHALL have master ports m_tdata, m_tlast, m_tstrb, m_tuser and m_tvalid as outputs with the same widths as REQ-006, and m_tready (1) as an input.
REQ-008 The block SHALL have output count, width $clog2(DEPTH)+1: the number of stored beats.
REQ-009 The block SHALL have output pkt_cnt, width $clog2(DEPTH)+1: the number of complete packets stored.
REQ-010 The block SHALL have outputs full (1 bit) and empty (1 bit).

Function
REQ-011 A beat SHALL be accepted when s_tvalid && s_tready at a clock edge; the beat is {tdata, tstrb, tuser, tlast}, stored unmodified.
REQ-012 A beat SHALL be popped when m_tvalid && m_tready at a clock edge.
REQ-013 s_tready SHALL equal !full; full SHALL be (count==DEPTH); empty SHALL be (count==0).
REQ-014 A full FIFO SHALL not accept a beat in the same cycle as a pop; s_tready rises only in the cycle after the pop.
REQ-015 Operation SHALL be first-word-fall-through: a beat accepted at edge k into an empty FIFO is presented on m_* in the cycle after edge k, so latency is 1 cycle.
REQ-016 While m_tvalid && !m_tready, all m_* outputs SHALL hold stable.
REQ-017 When m_tvalid=0, m_tdata, m_tstrb, m_tuser and m_tlast SHALL be driven to 0.
REQ-018 count SHALL update as follows: push only gives +1; pop only gives -1; push and pop together leave it unchanged.
REQ-019 Read and write pointers SHALL wrap from DEPTH-1 to 0.
REQ-020 Beats SHALL leave in acceptance order with no loss or duplication.
REQ-021 pkt_cnt SHALL update as follows: accepted beat with tlast=1 gives +1; popped beat with tlast=1 gives -1; both in the same cycle leave it unchanged.
REQ-022 Input stalls SHALL be tolerated at any beat; there is no tkeep/tstrb-based compaction.

Reset
REQ-023 While rst=1 at an edge, the block SHALL clear the pointers, count and pkt_cnt, and drive m_tvalid=0, s_tready=0, full=0, empty=1 and m_* data=0.
REQ-024 Reset mid-packet SHALL discard all stored beats, including partial packets.
REQ-025 s_tready SHALL be 1 from the first cycle after reset is released.

Configuration
REQ-026 Macro AXIS_STREAM_FIFO_PKT_MODE_EN SHALL select store-and-forward packet mode.
REQ-027 With AXIS_STREAM_FIFO_PKT_MODE_EN defined, m_tvalid SHALL equal !empty && (pkt_cnt>0 || full); the full term forces cut-through for a packet longer than DEPTH to avoid deadlock.
REQ-028 Without AXIS_STREAM_FIFO_PKT_MODE_EN, m_tvalid SHALL equal !empty, pkt_cnt SHALL be tied to 0 and the pkt_cnt logic SHALL be removed.

Verification
REQ-029 Bench scenario, single beat, DEPTH=16: push 0xA5 with tlast=1 at edge 1, m_tready=1 -> m_tvalid=1 with m_tdata=0xA5 after edge 1; popped at edge 2; empty=1 after edge 2.
REQ-030 Bench scenario, fill: hold m_tready=0 and push 16 beats -> count=16, full=1, s_tready=0; 17th beat not accepted; one pop -> s_tready=1 next cycle, count=15.
REQ-031 Bench scenario, wrap: 40 beats of an incrementing pattern with random s_tvalid/m_tready (50%) -> output sequence 0..39 exact and count returns to 0.
REQ-032 Bench scenario, packet mode: push a 4-beat packet with m_tready=1 -> m_tvalid=0 until tlast is accepted, then pkt_cnt=1 and 4 beats out back-to-back; pkt_cnt=0 afterward.
REQ-033 Bench scenario, packet mode overlong: 20-beat packet into DEPTH=16 -> at full, m_tvalid=1 and all 20 beats are delivered in order.
REQ-034 Bench scenario, reset mid-packet: 5 beats stored, then rst=1 for 1 cycle -> count=0, m_tvalid=0, pkt_cnt=0, and a new packet is passed correctly.
